// File: rtl/sar_seq_pkg.sv
// Shared definitions for the SAR ADC sequencer: FSM state encodings and
// the watchdog counter width.
package sar_seq_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_TICK = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_CONV      = 3'd3;
  localparam logic [2:0] ST_ACCUM     = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    WAIT_TICK = ST_WAIT_TICK,
    START     = ST_START,
    CONV      = ST_CONV,
    ACCUM     = ST_ACCUM
  } state_t;

  localparam int WD_W = 8;

endpackage

// File: rtl/sar_period_timer.sv
// Trigger period down-counter: reloads from period after reaching zero and
// is held at period while the sequencer is not enabled.
module sar_period_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                f100m_clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;

  always_ff @(posedge f100m_clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable || count == '0) begin
      count <= period;
    end else begin
      count <= count - PERIOD_W'(1);
    end
  end

  // period = 0 keeps count at zero, so the tick fires every enabled cycle.
  assign tick = enable && (count == '0);

endmodule

// File: rtl/sar_sequencer.sv
// SAR ADC control stage: periodic start requests, conversion tracking with
// a watchdog, oversampling average and a valid/ready result port.
module sar_sequencer
  import sar_seq_pkg::*;
#(
  parameter int NSTEP    = 10,
  parameter int OSR_LOG2 = 2,
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                f100m_clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clear,
  output logic                sar_soc,
  input  logic                sar_eoc,
  input  logic                sar_err,
  input  logic                sar_warn,
  input  logic [NSTEP-1:0]    sar_code,
  output logic [NSTEP-1:0]    data,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                flag_err,
  output logic                flag_timeout,
  output logic                flag_ovr,
  output logic                flag_miss,
  output logic                busy
);

  localparam int ACC_W = NSTEP + OSR_LOG2;
  localparam int CNT_W = OSR_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << OSR_LOG2) - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] count;
  logic [NSTEP-1:0] code;
  logic [WD_W-1:0]  wd;
  logic             bad;
  logic             tick;

  sar_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .f100m_clk (f100m_clk),
    .rst       (rst),
    .enable    (enable),
    .period    (period),
    .tick      (tick)
  );

  assign sum = acc + ACC_W'(code);

  always_ff @(posedge f100m_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sar_soc      <= 1'b0;
      data         <= '0;
      data_valid   <= 1'b0;
      flag_err     <= 1'b0;
      flag_timeout <= 1'b0;
      flag_ovr     <= 1'b0;
      flag_miss    <= 1'b0;
      busy         <= 1'b0;
      acc          <= '0;
      count        <= '0;
      code         <= '0;
      wd           <= '0;
      bad          <= 1'b0;
    end else begin
      if (data_valid && data_ready) data_valid <= 1'b0;
      if (tick && state != IDLE && state != WAIT_TICK) flag_miss <= 1'b1;
      // Free-running; only meaningful in START/CONV, where entry clears it.
      wd <= wd + WD_W'(1);

      case (state)
        IDLE: begin
          if (enable) state <= WAIT_TICK;
        end

        WAIT_TICK: begin
          if (tick) begin
            state   <= START;
            sar_soc <= 1'b1;
            busy    <= 1'b1;
            wd      <= '0;
          end else if (!enable) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
          end
        end

        START: begin
          if (!sar_eoc) begin
            state   <= CONV;
            sar_soc <= 1'b0;
            wd      <= '0;
            bad     <= 1'b0;
          end else if (wd == WD_LAST) begin
            state        <= WAIT_TICK;
            sar_soc      <= 1'b0;
            busy         <= 1'b0;
            flag_timeout <= 1'b1;
            acc          <= '0;
            count        <= '0;
          end
        end

        CONV: begin
          bad <= bad | sar_err | sar_warn;
          if (sar_eoc) begin
            state <= ACCUM;
            code  <= sar_code;
          end else if (wd == WD_LAST) begin
            state        <= WAIT_TICK;
            busy         <= 1'b0;
            flag_timeout <= 1'b1;
            acc          <= '0;
            count        <= '0;
          end
        end

        ACCUM: begin
          state <= enable ? WAIT_TICK : IDLE;
          busy  <= 1'b0;
          if (bad) begin
            flag_err <= 1'b1;
            acc      <= '0;
            count    <= '0;
          end else if (count == CNT_LAST) begin
            data       <= sum[ACC_W-1:OSR_LOG2];
            data_valid <= 1'b1;
            if (data_valid && !data_ready) flag_ovr <= 1'b1;
            acc        <= '0;
            count      <= '0;
          end else if (!enable) begin
            acc   <= '0;
            count <= '0;
          end else begin
            acc   <= sum;
            count <= count + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase

      // NOTE: the last non-blocking assignment to a register in a block wins,
      // so placing clear after every set gives it priority in the same cycle.
      if (clear) begin
        flag_err     <= 1'b0;
        flag_timeout <= 1'b0;
        flag_ovr     <= 1'b0;
        flag_miss    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sar_sequencer.md
Name: sar_sequencer

Overview:
- Downstream and control stage for the generic SAR ADC.
- Generates periodic start-of-conversion requests and tracks each conversion through the ADC's sar_eoc level.
- Captures sar_code and accumulates 2^OSR_LOG2 conversions into one averaged result.
- Delivers each result over a valid/ready handshake, with sticky error, timeout, overrun and missed-trigger flags.

Parameters:
- NSTEP, 10: ADC code width.
- OSR_LOG2, 2: log2 of conversions averaged per result (0 = no averaging).
- PERIOD_W, 16: width of the trigger period register.
- TIMEOUT, 64: maximum cycles allowed in START or CONV before abort (must be < 2^8).

Ports:
- f100m_clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  run request; level.
- period  in  PERIOD_W  cycles between triggers, minus 1.
- clear  in  1  single-cycle pulse; clears all sticky flags.
- sar_soc  out  1  start request level to the ADC.
- sar_eoc  in  1  ADC end-of-conversion level: high = idle, low = converting.
- sar_err  in  1  ADC comparator stuck flag.
- sar_warn  in  1  ADC counter overflow flag.
- sar_code  in  NSTEP  ADC result, valid when sar_eoc rises.
- data  out  NSTEP  averaged result.
- data_valid  out  1  result available.
- data_ready  in  1  consumer accepts result.
- flag_err  out  1  sticky: sar_err or sar_warn seen during CONV.
- flag_timeout  out  1  sticky: START or CONV exceeded TIMEOUT.
- flag_ovr  out  1  sticky: result overwritten while unconsumed.
- flag_miss  out  1  sticky: trigger tick arrived while not in WAIT_TICK.
- busy  out  1  high in START, CONV or ACCUM.

Behaviour:
- Reset: all outputs and state go to 0; FSM enters IDLE; accumulator and sample count are 0.
- Period timer:
  - Counts down from period while enable=1; tick when the count is 0, then reload.
  - period=0 gives a tick every cycle.
  - Timer is held at period while enable=0.
- FSM states: IDLE, WAIT_TICK, START, CONV, ACCUM.
- IDLE: enable=1 -> WAIT_TICK next cycle.
- WAIT_TICK:
  - tick -> START, with sar_soc=1 registered in the same transition.
  - enable=0 -> IDLE.
- START:
  - sar_soc held at 1.
  - sar_eoc=0 sampled -> CONV with sar_soc=0.
  - Watchdog reaches TIMEOUT -> sar_soc=0, flag_timeout=1, burst discarded, go to WAIT_TICK.
- CONV:
  - sar_err or sar_warn sampled high in any cycle sets a burst-bad bit.
  - sar_eoc=1 sampled -> capture sar_code -> ACCUM.
  - Watchdog reaches TIMEOUT -> flag_timeout=1, burst discarded, go to WAIT_TICK.
- ACCUM (one cycle):
  - If burst-bad: flag_err=1, accumulator and count cleared, go to WAIT_TICK.
  - Otherwise acc += code and count += 1.
  - If count reaches 2^OSR_LOG2: data <= (acc+code) >> OSR_LOG2 (truncate), data_valid <= 1, acc and count cleared.
  - Next state is WAIT_TICK if enable=1, else IDLE. A partial burst is discarded when going to IDLE.
- Watchdog: 8-bit counter, cleared on entry to START and to CONV.
- Accumulator width: NSTEP+OSR_LOG2. It cannot overflow.
- Latency: data_valid rises 2 cycles after the cycle in which sar_eoc=1 is sampled in CONV.
- Handshake: data and data_valid stay stable until data_valid & data_ready. data_valid drops the cycle after acceptance.
- Overrun:
  - A new result while data_valid=1 and data_ready=0 overwrites data, keeps data_valid=1 and sets flag_ovr.
  - If data_ready=1 in that same cycle, the old result is accepted, the new one is loaded with data_valid=1, and no overrun is flagged.
- flag_miss: set by a tick in any state other than WAIT_TICK (IDLE excluded). The tick is dropped.
- enable falling:
  - In START or CONV, the current conversion completes (or times out); the analogue conversion is never aborted.
  - In WAIT_TICK, go straight to IDLE.
- Sticky flags:
  - clear has priority over a set in the same cycle.
  - Flags are not cleared by enable.
- A pending data_valid survives enable=0.

Decomposition:
- Shared package sar_seq_pkg: FSM state encodings (3-bit localparams) and the watchdog width constant.
- One sub-module: sar_period_timer (down-counter with reload, enable hold, tick output).

Test Plan:
- OSR_LOG2=2, period=9, ADC model returns codes 100, 101, 102, 103 -> one result data=101, data_valid high; sar_soc pulses 4 times, spaced 10 cycles.
- ADC model never lowers sar_eoc -> sar_soc drops after 64 cycles in START, flag_timeout=1, no data_valid; clear pulse -> flag_timeout=0.
- sar_err high during the 3rd conversion of a burst -> flag_err=1, that burst produces no result, the next clean burst produces the correct average.
- data_ready=0 across two completed bursts (average 200 then 300) -> data=300, data_valid=1, flag_ovr=1; data_ready=1 -> data_valid=0 on the next cycle.
- period=0 with a conversion lasting 12 cycles -> flag_miss=1, results still correct; enable dropped mid-CONV -> conversion finishes, partial burst discarded, FSM reaches IDLE, busy=0.
- Assert rst mid-CONV -> all outputs 0 immediately (asynchronous); after release with enable=1, the first sar_soc rises only after a full period.
